// File: rtl/modexp_word_io_pkg.sv
// Shared definitions for the ModExp word-serial operand/result buffer:
// FSM state encodings, command-rejection codes, default geometry and a
// width helper used to size bank/index fields.
package modexp_word_io_pkg;

  localparam int DEF_WORD_WIDTH   = 64;
  localparam int DEF_NUM_WORDS    = 64;
  localparam int DEF_NUM_OPERANDS = 3;

  // Encodings are visible on the debug state port, so keep them fixed.
  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_LOAD  = 3'd1,
    ST_RUN   = 3'd2,
    ST_DRAIN = 3'd3
  } state_e;

  // Reason a command was rejected; any non-NONE value pulses err_seq.
  typedef enum logic [2:0] {
    ERR_NONE       = 3'd0,
    ERR_BUSY       = 3'd1,
    ERR_BAD_SEL    = 3'd2,
    ERR_NOT_LOADED = 3'd3,
    ERR_NO_RESULT  = 3'd4
  } cmd_err_e;

  // $clog2 with a floor of one bit so single-entry fields stay legal.
  function automatic int clog2_min1(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/modexp_word_io_if.sv
// Word streams of the ModExp buffer: operand input stream (in_*) and
// result output stream (out_*).
// Handshake rule for both streams: a word transfers on a rising clock edge
// where valid and ready are both high; once valid is raised the source holds
// data (and out_last) unchanged until that transfer, and valid never depends
// combinationally on ready.
interface modexp_word_io_if
  import modexp_word_io_pkg::*;
#(
  parameter int WORD_WIDTH = DEF_WORD_WIDTH
);
  logic                  in_valid;
  logic                  in_ready;
  logic [WORD_WIDTH-1:0] in_data;
  logic                  out_valid;
  logic                  out_ready;
  logic [WORD_WIDTH-1:0] out_data;
  logic                  out_last;

  // Producer of operands / consumer of results.
  modport master (
    output in_valid, in_data, out_ready,
    input  in_ready, out_valid, out_data, out_last
  );

  // The buffer itself.
  modport slave (
    input  in_valid, in_data, out_ready,
    output in_ready, out_valid, out_data, out_last
  );
endinterface

// File: rtl/modexp_word_io_ram.sv
// modexp_word_ram: operand/result storage for the ModExp buffer.
// One write port, one registered read port (latency 1). Contents are not
// reset; only the read register is, so the read data output starts at zero.
module modexp_word_ram #(
  parameter int WIDTH  = 64,
  parameter int DEPTH  = 256,
  parameter int ADDR_W = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              wr_en_i,
  input  logic [ADDR_W-1:0] wr_addr_i,
  input  logic [WIDTH-1:0]  wr_data_i,
  input  logic [ADDR_W-1:0] rd_addr_i,
  output logic [WIDTH-1:0]  rd_data_o
);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [WIDTH-1:0] rd_data_q;

  // Write port; out-of-range addresses are dropped.
  always_ff @(posedge clk) begin
    if (wr_en_i && (int'(wr_addr_i) < DEPTH)) mem_q[wr_addr_i] <= wr_data_i;
  end

  // Registered read; out-of-range addresses hold the previous value.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) rd_data_q <= '0;
    else if (int'(rd_addr_i) < DEPTH) rd_data_q <= mem_q[rd_addr_i];
  end

  assign rd_data_o = rd_data_q;

endmodule

// File: rtl/modexp_word_io.sv
// modexp_word_io: word-serial operand/result buffer in front of the ModExp
// core. Sequences load -> compute -> drain over valid/ready streams, gives
// the core a latency-1 operand read port and a result write port.
// Optional feature macro: MODEXP_WORD_IO_PARITY_EN (adds in_par / par_err,
// even parity over each loaded word; a bad word blocks its bank's loaded flag).
module modexp_word_io
  import modexp_word_io_pkg::*;
#(
  parameter  int WORD_WIDTH   = DEF_WORD_WIDTH,
  parameter  int NUM_WORDS    = DEF_NUM_WORDS,
  parameter  int NUM_OPERANDS = DEF_NUM_OPERANDS,
  localparam int CNT_W        = clog2_min1(NUM_WORDS),
  localparam int SEL_W        = clog2_min1(NUM_OPERANDS)
) (
  input  logic                    clk,
  input  logic                    reset,
  modexp_word_io_if.slave         io,
  input  logic                    load_start,
  input  logic [SEL_W-1:0]        load_sel,
  input  logic                    compute_start,
  input  logic                    result_read,
  output logic                    core_start,
  input  logic                    core_done,
  input  logic [SEL_W-1:0]        core_rd_sel,
  input  logic [CNT_W-1:0]        core_rd_addr,
  output logic [WORD_WIDTH-1:0]   core_rd_data,
  input  logic                    core_wr_en,
  input  logic [CNT_W-1:0]        core_wr_addr,
  input  logic [WORD_WIDTH-1:0]   core_wr_data,
  output logic [NUM_OPERANDS-1:0] loaded,
  output logic                    result_valid,
  output logic                    busy,
  output logic                    err_seq,
`ifdef MODEXP_WORD_IO_PARITY_EN
  input  logic                    in_par,
  output logic                    par_err,
`endif
  output logic [2:0]              state
);

  // Bank NUM_OPERANDS is the result bank, so bank fields need one extra code.
  localparam int BANK_W = clog2_min1(NUM_OPERANDS + 1);
  localparam int DEPTH  = (NUM_OPERANDS + 1) * NUM_WORDS;
  localparam int ADDR_W = clog2_min1(DEPTH);

  localparam logic [CNT_W-1:0]  LAST_IDX = CNT_W'(NUM_WORDS - 1);
  localparam logic [SEL_W:0]    NOPS     = (SEL_W + 1)'(NUM_OPERANDS);
  localparam logic [BANK_W-1:0] RES_BANK = BANK_W'(NUM_OPERANDS);

  state_e                  state_q;
  logic [CNT_W-1:0]        cnt_q;
  logic [SEL_W-1:0]        sel_q;
  logic [NUM_OPERANDS-1:0] loaded_q;
  logic                    result_valid_q;
  logic                    core_start_q;
  logic                    err_seq_q;
  logic                    out_valid_q;
  logic                    out_last_q;
  logic                    par_err_q;

  cmd_err_e          cmd_err;
  state_e            cmd_next;
  logic [CNT_W-1:0]  cnt_inc;
  logic              in_hs;
  logic              word_par_bad;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_waddr;
  logic [ADDR_W-1:0] mem_raddr;
  logic [WORD_WIDTH-1:0] mem_wdata;
  logic [WORD_WIDTH-1:0] mem_rdata;

  // Linear bank/index address; works for non-power-of-two NUM_WORDS.
  function automatic logic [ADDR_W-1:0] bank_addr(input logic [BANK_W-1:0] b,
                                                   input logic [CNT_W-1:0]  i);
    return ADDR_W'(b) * ADDR_W'(NUM_WORDS) + ADDR_W'(i);
  endfunction

  function automatic logic [NUM_OPERANDS-1:0] sel_mask(input logic [SEL_W-1:0] s);
    return NUM_OPERANDS'(1) << s;
  endfunction

  assign cnt_inc = cnt_q + CNT_W'(1);
  assign in_hs   = io.in_valid && (state_q == ST_LOAD);

`ifdef MODEXP_WORD_IO_PARITY_EN
  assign word_par_bad = (in_par != (^io.in_data));
  assign par_err      = par_err_q;
`else
  assign word_par_bad = 1'b0;
`endif

  // Command decode: only IDLE accepts commands, load > compute > read.
  always_comb begin
    cmd_err  = ERR_NONE;
    cmd_next = ST_IDLE;
    if (state_q != ST_IDLE) begin
      if (load_start || compute_start || result_read) cmd_err = ERR_BUSY;
    end else if (load_start) begin
      if ({1'b0, load_sel} >= NOPS) cmd_err = ERR_BAD_SEL;
      else                          cmd_next = ST_LOAD;
    end else if (compute_start) begin
      if (!(&loaded_q)) cmd_err = ERR_NOT_LOADED;
      else              cmd_next = ST_RUN;
    end else if (result_read) begin
      if (!result_valid_q) cmd_err = ERR_NO_RESULT;
      else                 cmd_next = ST_DRAIN;
    end
  end

  // Sequencer FSM with all status outputs registered.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q        <= ST_IDLE;
      cnt_q          <= '0;
      sel_q          <= '0;
      loaded_q       <= '0;
      result_valid_q <= 1'b0;
      core_start_q   <= 1'b0;
      err_seq_q      <= 1'b0;
      out_valid_q    <= 1'b0;
      out_last_q     <= 1'b0;
      par_err_q      <= 1'b0;
    end else begin
      err_seq_q    <= (cmd_err != ERR_NONE);
      core_start_q <= 1'b0;
      case (state_q)
        ST_IDLE: begin
          case (cmd_next)
            ST_LOAD: begin
              state_q        <= ST_LOAD;
              cnt_q          <= '0;
              sel_q          <= load_sel;
              loaded_q       <= loaded_q & ~sel_mask(load_sel);
              result_valid_q <= 1'b0;
              par_err_q      <= 1'b0;
            end
            ST_RUN: begin
              state_q      <= ST_RUN;
              core_start_q <= 1'b1;
            end
            ST_DRAIN: begin
              state_q     <= ST_DRAIN;
              cnt_q       <= '0;
              out_valid_q <= 1'b0;
              out_last_q  <= 1'b0;
            end
            default: ;
          endcase
        end
        ST_LOAD: begin
          if (in_hs) begin
            if (word_par_bad) par_err_q <= 1'b1;
            if (cnt_q == LAST_IDX) begin
              state_q <= ST_IDLE;
              if (!par_err_q && !word_par_bad) loaded_q <= loaded_q | sel_mask(sel_q);
            end else begin
              cnt_q <= cnt_inc;
            end
          end
        end
        ST_RUN: begin
          if (core_done) begin
            result_valid_q <= 1'b1;
            state_q        <= ST_IDLE;
          end
        end
        ST_DRAIN: begin
          // First DRAIN cycle prefetches word 0; afterwards cnt_q is the
          // index of the word currently presented.
          if (!out_valid_q) begin
            out_valid_q <= 1'b1;
            out_last_q  <= (cnt_q == LAST_IDX);
          end else if (io.out_ready) begin
            if (out_last_q) begin
              out_valid_q <= 1'b0;
              out_last_q  <= 1'b0;
              state_q     <= ST_IDLE;
            end else begin
              cnt_q      <= cnt_inc;
              out_last_q <= (cnt_inc == LAST_IDX);
            end
          end
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  // Memory port arbitration: loader owns the write port in LOAD, core in RUN;
  // drain owns the read port in DRAIN, core everywhere else. A stalled drain
  // re-reads the same word, keeping out_data stable.
  always_comb begin
    mem_we    = 1'b0;
    mem_waddr = bank_addr(BANK_W'(sel_q), cnt_q);
    mem_wdata = io.in_data;
    if (state_q == ST_LOAD) begin
      mem_we = in_hs;
    end else if ((state_q == ST_RUN) && core_wr_en && (core_wr_addr <= LAST_IDX)) begin
      mem_we    = 1'b1;
      mem_waddr = bank_addr(RES_BANK, core_wr_addr);
      mem_wdata = core_wr_data;
    end
    if (state_q == ST_DRAIN)
      mem_raddr = bank_addr(RES_BANK, (out_valid_q && io.out_ready) ? cnt_inc : cnt_q);
    else
      mem_raddr = bank_addr(BANK_W'(core_rd_sel), core_rd_addr);
  end

  modexp_word_ram #(
    .WIDTH (WORD_WIDTH),
    .DEPTH (DEPTH),
    .ADDR_W(ADDR_W)
  ) u_ram (
    .clk      (clk),
    .rst_n    (reset),
    .wr_en_i  (mem_we),
    .wr_addr_i(mem_waddr),
    .wr_data_i(mem_wdata),
    .rd_addr_i(mem_raddr),
    .rd_data_o(mem_rdata)
  );

  assign io.in_ready    = (state_q == ST_LOAD);
  assign io.out_valid   = out_valid_q;
  assign io.out_last    = out_last_q;
  assign io.out_data    = mem_rdata;
  assign core_rd_data   = mem_rdata;
  assign core_start     = core_start_q;
  assign loaded         = loaded_q;
  assign result_valid   = result_valid_q;
  assign busy           = (state_q != ST_IDLE);
  assign err_seq        = err_seq_q;
  assign state          = state_q;

endmodule
